// File: rtl/decode_hazard_controller.sv
// decode_hazard_controller: Decode-stage hazard unit for a 5-stage RV32I pipe.
// Tracks E/M/W destination records and drives the stall/flush controls and
// the Execute operand forwarding selects.
// Optional feature macro: FORWARDING_EN (defined = forwarding network present,
// load-use stalls only; undefined = no forwarding, stall on any E/M dependence).
module decode_hazard_controller #(
  parameter int REG_ADDR_BITS  = 5,
  parameter int STALL_CNT_BITS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      InstrValidD,
  input  logic [REG_ADDR_BITS-1:0]  Rs1D,
  input  logic [REG_ADDR_BITS-1:0]  Rs2D,
  input  logic                      UsesRs1D,
  input  logic                      UsesRs2D,
  input  logic [REG_ADDR_BITS-1:0]  RdD,
  input  logic                      RegWriteD,
  input  logic                      IsLoadD,
  input  logic                      PCSrcE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic [STALL_CNT_BITS-1:0] StallCount
);

  typedef struct packed {
    logic                     valid;
    logic [REG_ADDR_BITS-1:0] rd;
    logic                     regwrite;
    logic                     isload;
  } rec_t;

  typedef struct packed {
    rec_t                     base;
    logic [REG_ADDR_BITS-1:0] rs1;
    logic [REG_ADDR_BITS-1:0] rs2;
    logic                     uses1;
    logic                     uses2;
  } ex_rec_t;

  ex_rec_t                   e_rec;
  rec_t                      m_rec;
  rec_t                      w_rec;
  logic [STALL_CNT_BITS-1:0] cnt_q;

  logic dec_hit_e, dec_hit_m, stall_raw;
  logic [1:0] fwd_a, fwd_b;

  // True when record r writes a non-x0 register equal to a source that is read.
  function automatic logic rec_hit(rec_t r, logic [REG_ADDR_BITS-1:0] src, logic used);
    return used && r.valid && r.regwrite && (r.rd != '0) && (r.rd == src);
  endfunction

  assign dec_hit_e = InstrValidD &&
                     (rec_hit(e_rec.base, Rs1D, UsesRs1D) || rec_hit(e_rec.base, Rs2D, UsesRs2D));
  assign dec_hit_m = InstrValidD &&
                     (rec_hit(m_rec, Rs1D, UsesRs1D) || rec_hit(m_rec, Rs2D, UsesRs2D));

`ifdef FORWARDING_EN
  // Only a load in E cannot be forwarded in time; everything else is bypassed.
  assign stall_raw = dec_hit_e && e_rec.base.isload;

  // Operand selects for the instruction now in E; the younger M result wins over W.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rec_hit(m_rec, e_rec.rs1, e_rec.base.valid && e_rec.uses1))      fwd_a = 2'b10;
    else if (rec_hit(w_rec, e_rec.rs1, e_rec.base.valid && e_rec.uses1)) fwd_a = 2'b01;
    if (rec_hit(m_rec, e_rec.rs2, e_rec.base.valid && e_rec.uses2))      fwd_b = 2'b10;
    else if (rec_hit(w_rec, e_rec.rs2, e_rec.base.valid && e_rec.uses2)) fwd_b = 2'b01;
  end

  logic unused_bits;
  assign unused_bits = ^{m_rec.isload, w_rec.isload};
`else
  // Without a bypass network the consumer waits until the producer reaches W,
  // where the register file write-before-read covers it.
  assign stall_raw = dec_hit_e || dec_hit_m;
  assign fwd_a     = 2'b00;
  assign fwd_b     = 2'b00;

  logic unused_bits;
  assign unused_bits = ^{w_rec, e_rec.rs1, e_rec.rs2, e_rec.uses1, e_rec.uses2,
                         e_rec.base.isload, m_rec.isload};
`endif

  // Stall/flush resolution: a taken branch squashes, so flush overrides stall;
  // reset forces every output low.
  always_comb begin
    StallF     = 1'b0;
    StallD     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    ForwardAE  = 2'b00;
    ForwardBE  = 2'b00;
    StallCount = '0;
    if (!reset) begin
      ForwardAE  = fwd_a;
      ForwardBE  = fwd_b;
      StallCount = cnt_q;
      if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else begin
        StallF = stall_raw;
        StallD = stall_raw;
        FlushE = stall_raw;
      end
    end
  end

  // Shadow record pipeline and saturating load-use stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_rec <= '0;
      m_rec <= '0;
      w_rec <= '0;
      cnt_q <= '0;
    end else begin
      w_rec <= m_rec;
      m_rec <= e_rec.base;
      if (FlushE || StallD) begin
        e_rec <= '0;
      end else begin
        e_rec.base.valid    <= InstrValidD;
        e_rec.base.rd       <= RdD;
        e_rec.base.regwrite <= RegWriteD;
        e_rec.base.isload   <= IsLoadD;
        e_rec.rs1           <= Rs1D;
        e_rec.rs2           <= Rs2D;
        e_rec.uses1         <= UsesRs1D;
        e_rec.uses2         <= UsesRs2D;
      end
      if (StallD && !PCSrcE && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_hazard_controller.sv
// Bench for decode_hazard_controller: directed vector table for the scenario
// corners, then randomized traffic against an in-flight-instruction model.
module tb_decode_hazard_controller;
  localparam int RB = 5;
  localparam int CB = 4;  // small counter so saturation is reached

  logic          clk = 1'b0;
  logic          reset;
  logic          InstrValidD;
  logic [RB-1:0] Rs1D, Rs2D, RdD;
  logic          UsesRs1D, UsesRs2D, RegWriteD, IsLoadD, PCSrcE;
  logic          StallF, StallD, FlushD, FlushE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [CB-1:0] StallCount;

  always #5 clk = ~clk;

  decode_hazard_controller #(.REG_ADDR_BITS(RB), .STALL_CNT_BITS(CB)) dut (
    .clk(clk), .reset(reset), .InstrValidD(InstrValidD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .UsesRs1D(UsesRs1D), .UsesRs2D(UsesRs2D),
    .RdD(RdD), .RegWriteD(RegWriteD), .IsLoadD(IsLoadD), .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallCount(StallCount)
  );

  int checks = 0;
  int failures = 0;

  // Outputs packed as {StallF,StallD,FlushD,FlushE,FwdA,FwdB,StallCount}
  typedef struct {
    logic          rst, v;
    logic [RB-1:0] rs1, rs2;
    logic          u1, u2;
    logic [RB-1:0] rd;
    logic          rw, ld, pc;
    logic [11:0]   exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic v, int rs1, int rs2, logic u1, logic u2,
                              int rd, logic rw, logic ld, logic pc,
                              logic stl, logic fd, logic fe, int fa, int fb, int cnt);
    vec_t t;
    t.rst = rst; t.v = v; t.rs1 = RB'(rs1); t.rs2 = RB'(rs2); t.u1 = u1; t.u2 = u2;
    t.rd = RB'(rd); t.rw = rw; t.ld = ld; t.pc = pc;
    t.exp = {stl, stl, fd, fe, 2'(fa), 2'(fb), 4'(cnt)};
    return t;
  endfunction

  function automatic logic [11:0] actual();
    return {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCount};
  endfunction

  task automatic compare(string name, int idx, logic [11:0] exp);
    logic [11:0] act;
    act = actual();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got sF/sD/fD/fE/fA/fB/cnt=%b/%b/%b/%b/%b/%b/%0d want=%b/%b/%b/%b/%b/%b/%0d",
               name, idx, act[11], act[10], act[9], act[8], act[7:6], act[5:4], act[3:0],
               exp[11], exp[10], exp[9], exp[8], exp[7:6], exp[5:4], exp[3:0]);
    end
  endtask

  task automatic drive(logic rst, logic v, logic [RB-1:0] rs1, logic [RB-1:0] rs2,
                       logic u1, logic u2, logic [RB-1:0] rd, logic rw, logic ld, logic pc);
    reset = rst; InstrValidD = v; Rs1D = rs1; Rs2D = rs2; UsesRs1D = u1; UsesRs2D = u2;
    RdD = rd; RegWriteD = rw; IsLoadD = ld; PCSrcE = pc;
  endtask

  // ---------------- reference model: instructions in flight ----------------
  typedef struct {
    logic          valid;
    logic [RB-1:0] rd, rs1, rs2;
    logic          rw, ld, u1, u2;
  } instr_t;

  instr_t flight[3];  // [0]=Execute, [1]=Memory, [2]=Writeback
  int     mcnt;

  function automatic logic writes_to(instr_t i, logic [RB-1:0] r);
    return i.valid && i.rw && (i.rd != 0) && (i.rd == r);
  endfunction

  function automatic logic depends_on(instr_t i);
    return InstrValidD && ((UsesRs1D && writes_to(i, Rs1D)) || (UsesRs2D && writes_to(i, Rs2D)));
  endfunction

  function automatic logic [1:0] fsel(logic [RB-1:0] r, logic used);
    if (!flight[0].valid || !used) return 2'b00;
    if (writes_to(flight[1], r)) return 2'b10;
    if (writes_to(flight[2], r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [11:0] model();
    logic stl;
    logic [1:0] fa, fb;
    if (reset) return 12'd0;
`ifdef FORWARDING_EN
    stl = depends_on(flight[0]) && flight[0].ld;
    fa  = fsel(flight[0].rs1, flight[0].u1);
    fb  = fsel(flight[0].rs2, flight[0].u2);
`else
    stl = depends_on(flight[0]) || depends_on(flight[1]);
    fa  = 2'b00;
    fb  = 2'b00;
`endif
    if (PCSrcE) return {1'b0, 1'b0, 1'b1, 1'b1, fa, fb, 4'(mcnt)};
    return {stl, stl, 1'b0, stl, fa, fb, 4'(mcnt)};
  endfunction

  task automatic model_edge(logic [11:0] exp);
    instr_t d;
    if (reset) begin
      for (int i = 0; i < 3; i++) flight[i] = '{default: '0};
      mcnt = 0;
    end else begin
      if (exp[10] && mcnt < (1 << CB) - 1) mcnt++;
      d = '{valid: InstrValidD, rd: RdD, rs1: Rs1D, rs2: Rs2D,
            rw: RegWriteD, ld: IsLoadD, u1: UsesRs1D, u2: UsesRs2D};
      if (exp[8]) d = '{default: '0};
      flight[2] = flight[1];
      flight[1] = flight[0];
      flight[0] = d;
    end
  endtask

  initial begin
    logic [11:0] exp;
    //              rst v rs1 rs2 u1 u2 rd rw ld pc | stl fd fe fa fb cnt
`ifdef FORWARDING_EN
    tbl.push_back(mk(1,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1, 1, 2,1,1, 5,1,0,0, 0,0,0,0,0,0));  // add x5
    tbl.push_back(mk(0,1, 5, 3,1,1, 8,1,0,0, 0,0,0,0,0,0));  // add x8,x5,x3
    tbl.push_back(mk(0,1, 5, 5,1,1,10,1,0,0, 0,0,0,2,0,0));  // x5 from M
    tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,1,1,0));  // x5 from W
    tbl.push_back(mk(0,1, 1, 0,1,0, 6,1,1,0, 0,0,0,0,0,0));  // lw x6
    tbl.push_back(mk(0,1, 6, 1,1,1, 7,1,0,0, 1,0,1,0,0,0));  // load-use stall
    tbl.push_back(mk(0,1, 6, 1,1,1, 7,1,0,0, 0,0,0,0,0,1));  // released
    tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,1,0,1));  // x6 from W
    tbl.push_back(mk(0,1, 1, 0,1,0, 0,1,0,0, 0,0,0,0,0,1));  // addi x0
    tbl.push_back(mk(0,1, 0, 0,1,1,11,1,0,0, 0,0,0,0,0,1));  // use x0
    tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0,0,1));  // no x0 fwd
    tbl.push_back(mk(0,1, 1, 0,1,0,12,1,1,0, 0,0,0,0,0,1));  // lw x12
    tbl.push_back(mk(0,1,12,12,1,1,13,1,0,1, 0,1,1,0,0,1));  // load-use + branch
    tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0,0,1));
    tbl.push_back(mk(0,1, 1, 0,1,0,14,1,1,0, 0,0,0,0,0,1));  // lw x14
    tbl.push_back(mk(0,1,14, 0,1,0,15,1,0,0, 1,0,1,0,0,1));  // stall
    tbl.push_back(mk(1,1,14, 0,1,0,15,1,0,0, 0,0,0,0,0,0));  // reset mid-stall
    tbl.push_back(mk(0,1,14, 0,1,0,15,1,0,0, 0,0,0,0,0,0));  // clean after reset
`else
    tbl.push_back(mk(1,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1, 1, 2,1,1, 5,1,0,0, 0,0,0,0,0,0));  // add x5
    tbl.push_back(mk(0,1, 5, 3,1,1, 8,1,0,0, 1,0,1,0,0,0));  // dep on E
    tbl.push_back(mk(0,1, 5, 3,1,1, 8,1,0,0, 1,0,1,0,0,1));  // dep on M
    tbl.push_back(mk(0,1, 5, 3,1,1, 8,1,0,0, 0,0,0,0,0,2));  // producer in W
    tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0,0,2));  // no forwarding
    tbl.push_back(mk(0,1, 1, 0,1,0, 0,1,0,0, 0,0,0,0,0,2));  // addi x0
    tbl.push_back(mk(0,1, 0, 0,1,1,11,1,0,0, 0,0,0,0,0,2));  // use x0
    tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0,0,2));
    tbl.push_back(mk(0,1, 1, 0,1,0,12,1,0,0, 0,0,0,0,0,2));  // add x12
    tbl.push_back(mk(0,1,12,12,1,1,13,1,0,1, 0,1,1,0,0,2));  // dep + branch
    tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0,0,2));
    tbl.push_back(mk(0,1, 1, 0,1,0,14,1,0,0, 0,0,0,0,0,2));  // add x14
    tbl.push_back(mk(0,1,14, 0,1,0,15,1,0,0, 1,0,1,0,0,2));  // stall
    tbl.push_back(mk(1,1,14, 0,1,0,15,1,0,0, 0,0,0,0,0,0));  // reset mid-stall
    tbl.push_back(mk(0,1,14, 0,1,0,15,1,0,0, 0,0,0,0,0,0));  // clean after reset
`endif

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    // Directed vector table, one row per cycle.
    for (int i = 0; i < tbl.size(); i++) begin
      #1 drive(tbl[i].rst, tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2,
               tbl[i].rd, tbl[i].rw, tbl[i].ld, tbl[i].pc);
      @(negedge clk);
      compare("tbl", i, tbl[i].exp);
      @(posedge clk);
    end

    // Randomized traffic; small register range to make dependences frequent.
    for (int n = 0; n < 3000; n++) begin
      #1 drive((n == 0) || ($urandom_range(0, 199) == 0), $urandom_range(0, 7) != 0,
               RB'($urandom_range(0, 7)), RB'($urandom_range(0, 7)),
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
               RB'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      @(negedge clk);
      exp = model();
      compare("rnd", n, exp);
      model_edge(exp);
      @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decode_hazard_controller.md
# decode_hazard_controller

Hazard controller for the Register (decode) stage of the 5-stage RV32I pipeline. Keeps a shadow pipeline of destination-register records for Execute, Memory and Writeback. From it, the block generates:
- fetch/decode stall and decode/execute flush controls;
- Execute-stage operand forwarding selects.

It decides when the instruction currently decoded, with its extended immediate, may advance, and which result bus feeds each ALU operand.

## Interface
Parameters:
- REG_ADDR_BITS, 5, register index width
- STALL_CNT_BITS, 16, width of the stall performance counter

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- InstrValidD  in  1  a valid instruction occupies Decode
- Rs1D, Rs2D  in  REG_ADDR_BITS  source registers in Decode
- UsesRs1D, UsesRs2D  in  1  source is actually read (0 for U/J-type, rs2 0 for I-type)
- RdD  in  REG_ADDR_BITS  destination in Decode
- RegWriteD  in  1  Decode instruction writes Rd
- IsLoadD  in  1  Decode instruction is a load
- PCSrcE  in  1  taken branch/jump resolved in Execute
- StallF, StallD  out  1  hold PC and F/D register
- FlushD, FlushE  out  1  bubble F/D and D/E registers
- ForwardAE, ForwardBE  out  2  00 register file, 10 Memory result, 01 Writeback result
- StallCount  out  STALL_CNT_BITS  cycles spent in load-use stall, saturating

## Operation
- Record per stage E/M/W: valid, rd, regwrite, isload. E additionally holds rs1, rs2, uses1, uses2.
- Hazard match: a valid record with regwrite=1, rd≠0 and rd equal to a used Decode source. Register x0 never matches or forwards.
- Load-use (FORWARDING_EN defined): E record is a load and matches a Decode source with InstrValidD=1.
  - StallF=StallD=1, FlushE=1.
- Control hazard: PCSrcE=1 → FlushD=1, FlushE=1, StallF=StallD=0. Flush overrides stall in the same cycle.
- Record advance every clock edge:
  - W←M, M←E.
  - E←Decode fields when neither FlushE nor stall applies.
  - Otherwise E←invalid.
- Forwarding, evaluated on the E record's rs1/rs2 (ForwardAE/ForwardBE respectively), when the E source is used:
  - match in M → 10;
  - else match in W → 01;
  - else 00.
  - M has priority over W.
- StallCount increments on each cycle with StallD=1 and PCSrcE=0. It holds at all-ones.

## Timing
- Stall, flush and forward outputs are combinational from the current records and Decode inputs. They are valid in the same cycle.
- Records update on rising clk. A load-use stall lasts exactly 1 cycle with forwarding enabled.
- Reset (synchronous, dominates all inputs): all records invalid, StallCount=0.
  - Consequence: all outputs 0 in the cycle after reset is sampled, and while reset stays high.
- Reset asserted mid-stall: the next cycle shows no stall. The pending Decode instruction is the fetch logic's concern.
- Register file writes in the first half of Writeback, so W never causes a stall.

## Configuration
- FORWARDING_EN defined: behaviour as above.
- FORWARDING_EN undefined:
  - ForwardAE/ForwardBE are tied to 00.
  - StallF=StallD=FlushE=1 whenever a used Decode source matches a valid writing record in E or M, load or not.
  - Stall length is up to 2 cycles.
  - Flush still overrides stall.
  - StallCount counts all such stall cycles.

## Test plan
- Dependent ALU pair: add x5 in D, next instruction uses x5 → in the next cycle ForwardAE=10. One further instruction later → 01. No stall.
- Load-use: lw x6 then add x7,x6,x1 → exactly 1 cycle of StallF=StallD=FlushE=1. Then ForwardAE=01 and StallCount=1.
- x0 destination: addi x0 then use x0 → no stall, ForwardAE/ForwardBE stay 00.
- Simultaneous: load-use condition with PCSrcE=1 → FlushD=FlushE=1, StallD=0, StallCount unchanged.
- Reset mid-stall: reset high during a load-use stall → next cycle all outputs 0 and StallCount=0.
- FORWARDING_EN undefined: add x5 followed by use of x5 → 2 stall cycles, forwards always 00.
